// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with majority-vote mid-bit
// sampling, a valid/ready transmit handshake and a held receive register.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous active-low reset
//   rx         asynchronous serial input, idle high
//   tx         serial output, idle high
//   tx_data    word to transmit, latched on tx_valid & tx_ready
//   tx_valid   transmit request
//   tx_ready   transmitter idle and able to accept
//   rx_data    last received word
//   rx_valid   rx_data holds an unacknowledged word
//   rx_ack     consume rx_data
//   rx_perr    parity error of the held word
//   rx_ferr    framing error (first stop bit sampled 0) of the held word
//   rx_break   held word, parity and stop all 0
//   rx_overrun sticky: a word was overwritten before being acknowledged
module uart_core #(
  parameter int CLK_DIV   = 208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 32'sd0);
  localparam logic          ODD_PAR   = (PARITY == 32'sd1);

  // Parity bit that completes d to the configured odd/even count.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    logic p;
    p = ^d;
    if (ODD_PAR) return ~p;
    else         return p;
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_r, tx_state_s;
  logic [CW-1:0]        tx_cnt_r, tx_cnt_s;
  logic [IW-1:0]        tx_idx_r, tx_idx_s;
  logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
  logic                 tx_par_r, tx_par_s;
  logic                 tx_line_r, tx_line_s;
  logic                 tx_ready_r, tx_ready_s;
  logic                 tx_bit_end_s;

  assign tx_bit_end_s = (tx_cnt_r == CNT_LAST);

  // TX next-state: the line value for the coming bit is registered so tx is glitch-free.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_idx_s   = tx_idx_r;
    tx_shift_s = tx_shift_r;
    tx_par_s   = tx_par_r;
    tx_line_s  = tx_line_r;
    tx_ready_s = tx_ready_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_valid && tx_ready_r) begin
          tx_state_s = TX_START;
          tx_cnt_s   = CNT_ZERO;
          tx_idx_s   = IDX_ZERO;
          tx_shift_s = tx_data;
          tx_par_s   = parity_bit(tx_data);
          tx_line_s  = 1'b0;
          tx_ready_s = 1'b0;
        end else begin
          tx_cnt_s   = CNT_ZERO;
          tx_line_s  = 1'b1;
          tx_ready_s = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end_s) begin
          tx_state_s = TX_DATA;
          tx_cnt_s   = CNT_ZERO;
          tx_line_s  = tx_shift_r[0];
          tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_bit_end_s) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_idx_r == DATA_LAST) begin
            tx_idx_s = IDX_ZERO;
            if (HAS_PAR) begin
              tx_state_s = TX_PAR;
              tx_line_s  = tx_par_r;
            end else begin
              tx_state_s = TX_STOP;
              tx_line_s  = 1'b1;
            end
          end else begin
            tx_idx_s   = tx_idx_r + IDX_ONE;
            tx_line_s  = tx_shift_r[0];
            tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      TX_PAR: begin
        if (tx_bit_end_s) begin
          tx_state_s = TX_STOP;
          tx_cnt_s   = CNT_ZERO;
          tx_idx_s   = IDX_ZERO;
          tx_line_s  = 1'b1;
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_bit_end_s) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_idx_r == STOP_LAST) begin
            tx_state_s = TX_IDLE;
            tx_idx_s   = IDX_ZERO;
            tx_ready_s = 1'b1;
          end else begin
            tx_idx_s = tx_idx_r + IDX_ONE;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_cnt_s   = CNT_ZERO;
        tx_idx_s   = IDX_ZERO;
        tx_line_s  = 1'b1;
        tx_ready_s = 1'b1;
      end
    endcase
  end

  // TX state and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_idx_r   <= IDX_ZERO;
      tx_shift_r <= {DATA_BITS{1'b0}};
      tx_par_r   <= 1'b0;
      tx_line_r  <= 1'b1;
      tx_ready_r <= 1'b1;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_idx_r   <= tx_idx_s;
      tx_shift_r <= tx_shift_s;
      tx_par_r   <= tx_par_s;
      tx_line_r  <= tx_line_s;
      tx_ready_r <= tx_ready_s;
    end
  end

  assign tx       = tx_line_r;
  assign tx_ready = tx_ready_r;

  // ---------------- receiver ----------------
  logic                 rx_meta_r, rx_s_r, rx_d1_r, rx_d2_r;
  logic                 rx_maj_s;
  rx_state_t            rx_state_r, rx_state_s;
  logic [CW-1:0]        rx_cnt_r, rx_cnt_s;
  logic [IW-1:0]        rx_idx_r, rx_idx_s;
  logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
  logic                 rx_pbit_r, rx_pbit_s;
  logic                 rx_load_s;
  logic [DATA_BITS-1:0] rx_data_r, rx_data_s;
  logic                 rx_valid_r, rx_valid_s;
  logic                 rx_perr_r, rx_perr_s;
  logic                 rx_ferr_r, rx_ferr_s;
  logic                 rx_break_r, rx_break_s;
  logic                 rx_overrun_r, rx_overrun_s;

  // 2-of-3 vote over the current and two previous synchronised samples.
  assign rx_maj_s = (rx_s_r & rx_d1_r) | (rx_s_r & rx_d2_r) | (rx_d1_r & rx_d2_r);

  // RX next-state plus the held-word update on the stop decision.
  always_comb begin
    rx_state_s   = rx_state_r;
    rx_cnt_s     = rx_cnt_r;
    rx_idx_s     = rx_idx_r;
    rx_shift_s   = rx_shift_r;
    rx_pbit_s    = rx_pbit_r;
    rx_load_s    = 1'b0;
    rx_data_s    = rx_data_r;
    rx_valid_s   = rx_valid_r;
    rx_perr_s    = rx_perr_r;
    rx_ferr_s    = rx_ferr_r;
    rx_break_s   = rx_break_r;
    rx_overrun_s = rx_overrun_r;
    case (rx_state_r)
      RX_IDLE: begin
        // Counter starts at 1 so it equals the offset from t0 during START.
        if (!rx_s_r) begin
          rx_state_s = RX_START;
          rx_cnt_s   = CNT_ONE;
        end else begin
          rx_cnt_s = CNT_ZERO;
        end
      end
      RX_START: begin
        if (rx_cnt_r == CNT_HALF) begin
          rx_cnt_s = CNT_ZERO;
          rx_idx_s = IDX_ZERO;
          if (rx_maj_s) rx_state_s = RX_IDLE;
          else          rx_state_s = RX_DATA;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rx_maj_s, rx_shift_r[DATA_BITS-1:1]};
          if (rx_idx_r == DATA_LAST) begin
            rx_idx_s = IDX_ZERO;
            if (HAS_PAR) rx_state_s = RX_PAR;
            else         rx_state_s = RX_STOP;
          end else begin
            rx_idx_s = rx_idx_r + IDX_ONE;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_PAR: begin
        if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_pbit_s  = rx_maj_s;
          rx_state_s = RX_STOP;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_s  = CNT_ZERO;
          rx_load_s = 1'b1;
          if (rx_maj_s) rx_state_s = RX_IDLE;
          else          rx_state_s = RX_WAIT_HIGH;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low line must return high before a new start is accepted.
        if (rx_s_r) rx_state_s = RX_IDLE;
        else        rx_state_s = RX_WAIT_HIGH;
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = CNT_ZERO;
        rx_idx_s   = IDX_ZERO;
      end
    endcase

    if (rx_load_s) begin
      rx_data_s    = rx_shift_r;
      rx_valid_s   = 1'b1;
      rx_perr_s    = HAS_PAR && (parity_bit(rx_shift_r) != rx_pbit_r);
      rx_ferr_s    = ~rx_maj_s;
      rx_break_s   = ~rx_maj_s && (rx_shift_r == {DATA_BITS{1'b0}}) && (!HAS_PAR || !rx_pbit_r);
      // An ack coinciding with the load consumes the old word, so no overrun.
      rx_overrun_s = rx_valid_r && !rx_ack;
    end else if (rx_ack && rx_valid_r) begin
      rx_valid_s   = 1'b0;
      rx_overrun_s = 1'b0;
    end else begin
      rx_valid_s   = rx_valid_r;
    end
  end

  // RX synchroniser, vote history, FSM and held-word registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_r    <= 1'b1;
      rx_s_r       <= 1'b1;
      rx_d1_r      <= 1'b1;
      rx_d2_r      <= 1'b1;
      rx_state_r   <= RX_IDLE;
      rx_cnt_r     <= CNT_ZERO;
      rx_idx_r     <= IDX_ZERO;
      rx_shift_r   <= {DATA_BITS{1'b0}};
      rx_pbit_r    <= 1'b0;
      rx_data_r    <= {DATA_BITS{1'b0}};
      rx_valid_r   <= 1'b0;
      rx_perr_r    <= 1'b0;
      rx_ferr_r    <= 1'b0;
      rx_break_r   <= 1'b0;
      rx_overrun_r <= 1'b0;
    end else begin
      rx_meta_r    <= rx;
      rx_s_r       <= rx_meta_r;
      rx_d1_r      <= rx_s_r;
      rx_d2_r      <= rx_d1_r;
      rx_state_r   <= rx_state_s;
      rx_cnt_r     <= rx_cnt_s;
      rx_idx_r     <= rx_idx_s;
      rx_shift_r   <= rx_shift_s;
      rx_pbit_r    <= rx_pbit_s;
      rx_data_r    <= rx_data_s;
      rx_valid_r   <= rx_valid_s;
      rx_perr_r    <= rx_perr_s;
      rx_ferr_r    <= rx_ferr_s;
      rx_break_r   <= rx_break_s;
      rx_overrun_r <= rx_overrun_s;
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign rx_perr    = rx_perr_r;
  assign rx_ferr    = rx_ferr_r;
  assign rx_break   = rx_break_r;
  assign rx_overrun = rx_overrun_r;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core. Instance A: CLK_DIV=16, 8N1. Instance B: CLK_DIV=16,
// 7 data bits, even parity, 2 stop bits, with optional tx->rx loopback.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled there too.
module tb_uart_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic a_rx, a_tx, a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ack;
  logic a_perr, a_ferr, a_brk, a_ovr;
  logic [7:0] a_tx_data, a_rx_data;
  logic b_rx, b_rx_drv, b_loop, b_tx, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ack;
  logic b_perr, b_ferr, b_brk, b_ovr;
  logic [6:0] b_tx_data, b_rx_data;

  assign b_rx = b_loop ? b_tx : b_rx_drv;

  int n_pass  = 0;
  int n_total = 0;

  uart_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rx(a_rx), .tx(a_tx),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ack(a_rx_ack),
    .rx_perr(a_perr), .rx_ferr(a_ferr), .rx_break(a_brk), .rx_overrun(a_ovr));

  uart_core #(.CLK_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .rx(b_rx), .tx(b_tx),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ack(b_rx_ack),
    .rx_perr(b_perr), .rx_ferr(b_ferr), .rx_break(b_brk), .rx_overrun(b_ovr));

  // Drive one 8N1 frame on a_rx. c counts edges since the call; ack_at pulses
  // rx_ack in that cycle, glitch_at inverts the line for that one cycle.
  // first_valid = first c+1 after which rx_valid was seen high (-1 if never).
  task automatic send_a(input logic [7:0] d, input int ack_at, input int glitch_at,
                        output int first_valid);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    first_valid = -1;
    for (int c = 0; c < 160; c++) begin
      a_rx     = bits[c/16] ^ (c == glitch_at);
      a_rx_ack = (c == ack_at);
      @(posedge clk); #1;
      if (first_valid < 0 && a_rx_valid === 1'b1) first_valid = c + 1;
    end
    a_rx     = 1'b1;
    a_rx_ack = 1'b0;
  endtask

  // Drive one 11-bit frame (LSB first) on instance B's rx.
  task automatic send_b(input logic [10:0] bits);
    for (int c = 0; c < 176; c++) begin
      b_rx_drv = bits[c/16];
      @(posedge clk); #1;
    end
    b_rx_drv = 1'b1;
  endtask

  task automatic ack_a();
    a_rx_ack = 1'b1;
    @(posedge clk); #1;
    a_rx_ack = 1'b0;
  endtask

  task automatic ack_b();
    b_rx_ack = 1'b1;
    @(posedge clk); #1;
    b_rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({a_tx, a_tx_ready} !== 2'b11) $display("FAIL reset_a_tx: tx,tx_ready=%b, want 11", {a_tx, a_tx_ready});
    else n_pass++;
    n_total++;
    if ({a_rx_valid, a_perr, a_ferr, a_brk, a_ovr, a_rx_data} !== 13'h0)
      $display("FAIL reset_a_rx: got %h, want 0", {a_rx_valid, a_perr, a_ferr, a_brk, a_ovr, a_rx_data});
    else n_pass++;
    n_total++;
    if ({b_tx, b_tx_ready, b_rx_valid, b_perr, b_ferr, b_brk, b_ovr, b_rx_data} !== 14'h3000)
      $display("FAIL reset_b: got %h, want 3000", {b_tx, b_tx_ready, b_rx_valid, b_perr, b_ferr, b_brk, b_ovr, b_rx_data});
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // 0xA5 on 8N1: each level held 16 cycles, ready back after 160.
  task automatic test_tx_frame();
    logic [9:0] bits;
    int bad[10];
    int rdy_bad;
    bits = {1'b1, 8'hA5, 1'b0};
    rdy_bad = 0;
    for (int j = 0; j < 10; j++) bad[j] = 0;
    a_tx_data  = 8'hA5;
    a_tx_valid = 1'b1;
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (a_tx !== bits[i/16]) bad[i/16]++;
      if (a_tx_ready !== 1'b0) rdy_bad++;
      @(posedge clk); #1;
    end
    for (int j = 0; j < 10; j++) begin
      n_total++;
      if (bad[j] !== 0) $display("FAIL tx_bit%0d: %0d cycles differed from %b, want 0", j, bad[j], bits[j]);
      else n_pass++;
    end
    n_total++;
    if (rdy_bad !== 0) $display("FAIL tx_ready_busy: high in %0d frame cycles, want 0", rdy_bad);
    else n_pass++;
    n_total++;
    if ({a_tx, a_tx_ready} !== 2'b11) $display("FAIL tx_ready_rise: tx,ready=%b at +160, want 11", {a_tx, a_tx_ready});
    else n_pass++;
  endtask

  task automatic test_tx_back_to_back();
    int w1, w2;
    a_tx_data  = 8'h01;
    a_tx_valid = 1'b1;
    @(posedge clk); #1;
    a_tx_data = 8'h80;
    w1 = 0;
    while (a_tx_ready !== 1'b1 && w1 < 400) begin @(posedge clk); #1; w1++; end
    n_total++;
    if (w1 !== 160) $display("FAIL b2b_len1: ready after %0d cycles, want 160", w1);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({a_tx, a_tx_ready} !== 2'b00) $display("FAIL b2b_restart: tx,ready=%b, want 00", {a_tx, a_tx_ready});
    else n_pass++;
    a_tx_valid = 1'b0;
    w2 = 0;
    while (a_tx_ready !== 1'b1 && w2 < 400) begin @(posedge clk); #1; w2++; end
    n_total++;
    if (w2 !== 160) $display("FAIL b2b_len2: ready after %0d cycles, want 160", w2);
    else n_pass++;
  endtask

  task automatic test_rx_overrun();
    int fv;
    send_a(8'h11, -1, -1, fv);
    n_total++;
    if (fv !== 155) $display("FAIL rx_latency: rx_valid after %0d cycles, want 155", fv);
    else n_pass++;
    n_total++;
    if ({a_rx_valid, a_perr, a_ferr, a_brk, a_ovr, a_rx_data} !== {5'b10000, 8'h11})
      $display("FAIL rx_word_11: got %h, want %h", {a_rx_valid, a_perr, a_ferr, a_brk, a_ovr, a_rx_data}, {5'b10000, 8'h11});
    else n_pass++;
    send_a(8'h22, -1, -1, fv);
    n_total++;
    if ({a_rx_valid, a_ovr, a_rx_data} !== {2'b11, 8'h22})
      $display("FAIL overrun_set: valid,ovr,data=%h, want %h", {a_rx_valid, a_ovr, a_rx_data}, {2'b11, 8'h22});
    else n_pass++;
    ack_a();
    n_total++;
    if ({a_rx_valid, a_ovr, a_rx_data} !== {2'b00, 8'h22})
      $display("FAIL overrun_ack: valid,ovr,data=%h, want %h", {a_rx_valid, a_ovr, a_rx_data}, {2'b00, 8'h22});
    else n_pass++;
    send_a(8'h33, -1, -1, fv);
    send_a(8'h44, 154, -1, fv);
    n_total++;
    if ({a_rx_valid, a_ovr, a_rx_data} !== {2'b10, 8'h44})
      $display("FAIL ack_with_load: valid,ovr,data=%h, want %h", {a_rx_valid, a_ovr, a_rx_data}, {2'b10, 8'h44});
    else n_pass++;
    ack_a();
  endtask

  task automatic test_rx_glitch();
    int fv;
    a_rx = 1'b0;
    @(posedge clk); #1;
    a_rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    n_total++;
    if (a_rx_valid !== 1'b0) $display("FAIL false_start: rx_valid=%b, want 0", a_rx_valid);
    else n_pass++;
    // One-cycle low exactly at the bit-3 decision point is outvoted.
    send_a(8'hFF, -1, 56, fv);
    n_total++;
    if ({a_rx_valid, a_ferr, a_rx_data} !== {2'b10, 8'hFF})
      $display("FAIL glitch_mid_bit: valid,ferr,data=%h, want %h", {a_rx_valid, a_ferr, a_rx_data}, {2'b10, 8'hFF});
    else n_pass++;
    ack_a();
  endtask

  task automatic test_rx_break();
    int fv;
    a_rx = 1'b0;
    repeat (480) @(posedge clk);
    #1;
    n_total++;
    if ({a_rx_valid, a_brk, a_ferr, a_ovr, a_rx_data} !== {4'b1110, 8'h00})
      $display("FAIL break_word: valid,brk,ferr,ovr,data=%h, want %h", {a_rx_valid, a_brk, a_ferr, a_ovr, a_rx_data}, {4'b1110, 8'h00});
    else n_pass++;
    ack_a();
    repeat (32) @(posedge clk);
    #1;
    a_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_total++;
    if (a_rx_valid !== 1'b0) $display("FAIL break_no_retrigger: rx_valid=%b, want 0", a_rx_valid);
    else n_pass++;
    send_a(8'h5A, -1, -1, fv);
    n_total++;
    if ({a_rx_valid, a_brk, a_ferr, a_rx_data} !== {3'b100, 8'h5A})
      $display("FAIL after_break: valid,brk,ferr,data=%h, want %h", {a_rx_valid, a_brk, a_ferr, a_rx_data}, {3'b100, 8'h5A});
    else n_pass++;
    ack_a();
  endtask

  // 7E2 frames: {stop2, stop1, parity, data[6:0], start}.
  task automatic test_parity_framing();
    b_loop = 1'b0;
    send_b({2'b11, 1'b1, 7'h3C, 1'b0});
    n_total++;
    if ({b_rx_valid, b_perr, b_ferr, b_rx_data} !== {3'b110, 7'h3C})
      $display("FAIL parity_err: valid,perr,ferr,data=%h, want %h", {b_rx_valid, b_perr, b_ferr, b_rx_data}, {3'b110, 7'h3C});
    else n_pass++;
    ack_b();
    send_b({2'b10, 1'b0, 7'h55, 1'b0});
    n_total++;
    if ({b_rx_valid, b_perr, b_ferr, b_brk, b_rx_data} !== {4'b1010, 7'h55})
      $display("FAIL framing_err: valid,perr,ferr,brk,data=%h, want %h", {b_rx_valid, b_perr, b_ferr, b_brk, b_rx_data}, {4'b1010, 7'h55});
    else n_pass++;
    ack_b();
  endtask

  task automatic test_loopback();
    b_loop = 1'b1;
    fork
      begin
        for (int i = 0; i < 128; i++) begin
          int w;
          w = 0;
          b_tx_data  = i[6:0];
          b_tx_valid = 1'b1;
          while (b_tx_ready !== 1'b1 && w < 400) begin @(posedge clk); #1; w++; end
          @(posedge clk); #1;
        end
        b_tx_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 128; j++) begin
          int w;
          w = 0;
          while (b_rx_valid !== 1'b1 && w < 600) begin @(posedge clk); #1; w++; end
          n_total++;
          if ({b_rx_valid, b_perr, b_ferr, b_ovr, b_rx_data} !== {4'b1000, j[6:0]})
            $display("FAIL loopback_%0d: valid,perr,ferr,ovr,data=%h, want %h", j, {b_rx_valid, b_perr, b_ferr, b_ovr, b_rx_data}, {4'b1000, j[6:0]});
          else n_pass++;
          ack_b();
        end
      end
    join
    b_loop = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    send_b({2'b11, 1'b1, 7'h2A, 1'b0});
    n_total++;
    if ({b_rx_valid, b_perr, b_ferr, b_rx_data} !== {3'b100, 7'h2A})
      $display("FAIL pre_reset_word: valid,perr,ferr,data=%h, want %h", {b_rx_valid, b_perr, b_ferr, b_rx_data}, {3'b100, 7'h2A});
    else n_pass++;
    a_tx_data  = 8'hC3;
    a_tx_valid = 1'b1;
    b_rx_drv   = 1'b0;
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_total++;
    if (a_tx_ready !== 1'b0) $display("FAIL mid_tx_busy: tx_ready=%b, want 0", a_tx_ready);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({a_tx, a_tx_ready} !== 2'b11) $display("FAIL reset_mid_tx: tx,ready=%b, want 11", {a_tx, a_tx_ready});
    else n_pass++;
    n_total++;
    if ({b_rx_valid, b_perr, b_ferr, b_brk, b_ovr, b_rx_data} !== 12'h000)
      $display("FAIL reset_mid_rx: got %h, want 000", {b_rx_valid, b_perr, b_ferr, b_brk, b_ovr, b_rx_data});
    else n_pass++;
    b_rx_drv = 1'b1;
    reset    = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_total++;
    if ({a_tx, a_tx_ready, b_rx_valid} !== 3'b110)
      $display("FAIL after_reset_idle: tx,ready,b_valid=%b, want 110", {a_tx, a_tx_ready, b_rx_valid});
    else n_pass++;
  endtask

  initial begin
    reset      = 1'b0;
    a_rx       = 1'b1;
    a_tx_data  = 8'h00;
    a_tx_valid = 1'b0;
    a_rx_ack   = 1'b0;
    b_rx_drv   = 1'b1;
    b_loop     = 1'b0;
    b_tx_data  = 7'h00;
    b_tx_valid = 1'b0;
    b_rx_ack   = 1'b0;
    test_reset();
    test_tx_frame();
    test_tx_back_to_back();
    test_rx_overrun();
    test_rx_glitch();
    test_rx_break();
    test_parity_framing();
    test_loopback();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART replacing the separate fixed 8N1 receiver/transmitter pair. It is configurable in data width, parity, stop bits and bit period, and uses majority-vote mid-bit sampling. It adds a valid/ready transmit handshake, a held receive register with acknowledge, and parity, framing, break and overrun status. It sits between the board RX/TX pins and the dumper/command logic, in the single system clock domain.

## Interface
- CLK_DIV, 208: clk cycles per bit. Legal range ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- rx  in  1  serial line in, asynchronous, idle high
- tx  out  1  serial line out, idle high
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  transmitter idle, can accept
- rx_data  out  DATA_BITS  last received word
- rx_valid  out  1  rx_data holds an unacknowledged word
- rx_ack  in  1  consume rx_data; clears rx_valid
- rx_perr  out  1  parity error of the word in rx_data
- rx_ferr  out  1  framing error (stop sample = 0) of the word in rx_data
- rx_break  out  1  word and parity all 0 and stop = 0
- rx_overrun  out  1  sticky; a word was overwritten before being acknowledged

## Operation
- Reset (reset = 0 at a clk edge) gives the following values, and the block holds them while reset is low:
  - tx = 1, tx_ready = 1.
  - rx_valid = 0, rx_perr = 0, rx_ferr = 0, rx_break = 0, rx_overrun = 0, rx_data = 0.
  - Both FSMs return to IDLE and all counters are 0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 on the next edge.
- TX FSM: IDLE → START → DATA (DATA_BITS bits) → PARITY (only when PARITY ≠ 0) → STOP (STOP_BITS bits) → IDLE.
  - A transfer is accepted when tx_valid & tx_ready. tx_data is latched, and tx_ready drops on the same edge.
  - Every bit is driven for exactly CLK_DIV cycles.
  - Parity bit: odd mode makes the count of data bits plus parity odd; even mode makes it even.
  - tx_valid while tx_ready = 0 is ignored. No queueing.
- RX path:
  - A 2-FF synchroniser feeds rx_s. All RX timing below refers to rx_s.
  - RX FSM: IDLE → START → DATA → PARITY (only when PARITY ≠ 0) → STOP → IDLE or WAIT_HIGH.
  - Let t0 be the first cycle in IDLE with rx_s = 0.
  - Bit n (n = 0 is the start bit) is decided at t0 + CLK_DIV/2 + n·CLK_DIV (integer divide). The value is the majority of rx_s at that cycle and the two preceding cycles.
  - False start: if the start-bit majority is 1, return to IDLE with no flags and no output change.
  - Only the first stop bit is checked. After the stop decision the FSM goes to IDLE if the stop bit was 1, and to WAIT_HIGH if it was 0.
  - WAIT_HIGH → IDLE when rx_s = 1. This stops a held-low line (break) from retriggering.
  - On the cycle after the stop decision, the following update together:
    - rx_data
    - rx_perr (parity mismatch; always 0 when PARITY = 0)
    - rx_ferr
    - rx_break
    - rx_valid ← 1
  - Overrun: if rx_valid = 1 and rx_ack = 0 in that load cycle, the new word overwrites the held one and rx_overrun ← 1.
    - rx_ack in the same cycle as a load counts as acknowledging the old word: no overrun, and rx_valid stays 1.
  - rx_ack while rx_valid = 1 clears rx_valid and rx_overrun on the next edge. rx_data and the error flags hold until the next load.
- Arithmetic:
  - Bit counters are $clog2(CLK_DIV) wide and wrap to 0 at CLK_DIV−1. There is no free-running counter.
  - The bit index counter is $clog2(DATA_BITS+1) wide.

## Timing
- TX latency: accept at edge k → tx = 0 from cycle k+1.
- TX frame length is CLK_DIV·(1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles. tx_ready rises on the first cycle after the last stop bit.
- Back-to-back TX: with tx_valid held high, the next start bit begins one cycle after tx_ready rises.
- RX latency: rx_valid rises at t0 + CLK_DIV/2 + (DATA_BITS + (PARITY≠0) + 1)·CLK_DIV + 1. From the rx pin edge this is 2 cycles more (synchroniser).
- Tolerance: majority sampling at mid-bit tolerates one-cycle glitches and ±4 % baud mismatch at CLK_DIV ≥ 16.

## Test plan
- CLK_DIV = 16, 8N1: send 0xA5 → tx is 0, 1,0,1,0,0,1,0,1, then 1. Each level lasts 16 cycles, and tx_ready rises 160 cycles after accept.
- Loopback (tx → rx), DATA_BITS = 7, PARITY = 2, STOP_BITS = 2: send 0x00..0x7F back-to-back → every word returns, with rx_perr = rx_ferr = 0.
- Drive 0x3C with wrong even parity → rx_valid = 1, rx_data = 0x3C, rx_perr = 1. Then drive a 0x55 frame with stop = 0 → rx_ferr = 1.
- Hold rx low for 30 bit times → exactly one word: rx_data = 0, rx_break = 1, rx_ferr = 1. No further rx_valid loads until rx has been high, then a new frame is received normally.
- Receive 0x11 then 0x22 without rx_ack → rx_data = 0x22, rx_overrun = 1. Pulse rx_ack → rx_valid = 0 and rx_overrun = 0 next cycle. Repeat with rx_ack coincident with the second load → rx_overrun stays 0.
- Glitch and reset cases:
  - A 1-cycle rx low pulse in IDLE → no rx_valid (false start).
  - Assert reset mid-TX-frame → tx = 1 and tx_ready = 1 on the next edge.
  - Assert reset mid-RX-frame → all rx outputs are 0.
